key_event_ctrl: RTL and testbench

- Sits between the keyboard scanner (4-bit key code plus key-present level) and the calculator core.
- Debounces the scanner's key-present level and emits exactly one key event per debounced press.
- Buffers events in a small first-word-fall-through FIFO and hands them to the core over a valid/ready handshake.
- Flags lost keys with a sticky overflow bit.

---
 rtl/key_event_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Keypad front end: debounces the scanner's key-present level, queues one event per press
// in a FWFT FIFO, and raises a sticky overflow flag when a key is lost. Optional auto-repeat
// is enabled by defining KEY_EVENT_CTRL_AUTOREPEAT_EN.
module key_event_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            KeyRead,
    input  logic [3:0]                      BCDKey,
    input  logic                            KEY_READY,
    input  logic                            CLR_OVF,
    output logic [3:0]                      KEY_CODE,
    output logic                            KEY_VALID,
    output logic                            OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]     FIFO_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    DB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] cap_q, cap_d;
    logic       db_push;
    logic       push_req;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        db_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (KeyRead) begin
                    cap_d   = BCDKey;
                    cnt_d   = 8'd1;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (KeyRead && BCDKey == cap_q) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == DB_LAST) begin
                        db_push = 1'b1;
                        state_d = HELD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (!KeyRead) begin
                    cnt_d   = 8'd1;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (KeyRead) begin
                    state_d = HELD;  // release bounce: back to held, no new event
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == DB_LAST) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

`ifdef KEY_EVENT_CTRL_AUTOREPEAT_EN
    logic [15:0] rep_q, rep_d;
    logic        rep_first_q, rep_first_d;
    logic        rep_push;

    // Counter freezes in RELEASE so a release bounce resumes the same repeat schedule.
    always_comb begin
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        rep_push    = 1'b0;
        case (state_q)
            HELD: begin
                if (KeyRead) begin
                    rep_d = rep_q + 16'd1;
                    if (rep_d == (rep_first_q ? 16'(REPEAT_DELAY) : 16'(REPEAT_PERIOD))) begin
                        rep_push    = 1'b1;
                        rep_d       = '0;
                        rep_first_d = 1'b0;
                    end
                end
            end
            RELEASE: begin
                rep_d       = rep_q;
                rep_first_d = rep_first_q;
            end
            default: begin
                rep_d       = '0;
                rep_first_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rep_q       <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
        end
    end

    assign push_req = db_push | rep_push;
`else
    assign push_req = db_push;
`endif

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count_q;
    logic [3:0]    head_q;
    logic          ovf_q;
    logic          pop, push_ok, drop;

    assign pop     = (count_q != '0) && KEY_READY;
    assign push_ok = push_req && ((count_q != FULL) || pop);
    assign drop    = push_req && (count_q == FULL) && !pop;
    assign rd_next = rd_ptr + 1'b1;

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= cap_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_next;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;

            // Head register keeps KEY_CODE a flop output under fall-through.
            if (push_ok && (count_q == '0 || (count_q == CW'(1) && pop)))
                head_q <= cap_q;
            else if (pop && count_q > CW'(1))
                head_q <= mem[rd_next];

            if (drop)         ovf_q <= 1'b1;
            else if (CLR_OVF) ovf_q <= 1'b0;
        end
    end

    assign KEY_CODE   = head_q;
    assign KEY_VALID  = (count_q != '0);
    assign OVERFLOW   = ovf_q;
    assign FIFO_COUNT = count_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Randomized plus directed bench for key_event_ctrl with a sample-stream reference model
// and a scoreboard queue drained by an independent output monitor.
module tb_key_event_ctrl;

    localparam int N     = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_read = 1'b0;
    logic [3:0] bcd = 4'h0;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] key_code;
    logic       key_valid;
    logic       ovf;
    logic [2:0] fifo_count;

    key_event_ctrl dut (
        .CLK(clk), .RESET(rst_n), .KeyRead(key_read), .BCDKey(bcd),
        .KEY_READY(ready), .CLR_OVF(clr), .KEY_CODE(key_code),
        .KEY_VALID(key_valid), .OVERFLOW(ovf), .FIFO_COUNT(fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: runs of stable samples decide press/release; FIFO is an occupancy count
    // plus a queue of accepted codes in arrival order.
    logic [3:0] exp_q[$];
    int         m_count = 0;
    bit         m_ovf = 0;
    bit         pressed = 0;
    int         run_len = 0;
    int         rel_len = 0;
    logic [3:0] run_code = 4'h0;
    bit         mon_en = 0;

    task automatic model_update();
        bit ev;
        if (!rst_n) begin
            pressed = 0; run_len = 0; rel_len = 0;
            m_count = 0; m_ovf = 0; exp_q.delete();
            return;
        end
        ev = 0;
        if (!pressed) begin
            if (!key_read)          run_len = 0;
            else if (run_len == 0)  begin run_len = 1; run_code = bcd; end
            else if (bcd == run_code) run_len++;
            else                    run_len = 0;
            if (run_len == N) begin ev = 1; pressed = 1; rel_len = 0; end
        end else begin
            if (key_read) rel_len = 0;
            else          rel_len++;
            if (rel_len == N) begin pressed = 0; run_len = 0; end
        end
        if (m_count != 0 && ready) m_count--;
        if (ev) begin
            if (m_count < DEPTH) begin
                m_count++;
                exp_q.push_back(run_code);
            end else begin
                m_ovf = 1;
            end
        end else if (clr) begin
            m_ovf = 0;
        end
    endtask

    // Monitor: state checks every cycle; a handshake pops the scoreboard and compares the code.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid", 32'(key_valid), 32'(m_count != 0));
            check("count", 32'(fifo_count), 32'(m_count));
            check("overflow", 32'(ovf), 32'(m_ovf));
            if (rst_n && key_valid && ready) begin
                if (exp_q.size() == 0) check("pop_unexpected", 32'(key_code), 32'hFFFF_FFFF);
                else                   check("pop_code", 32'(key_code), 32'(exp_q.pop_front()));
            end else if (key_valid && exp_q.size() != 0) begin
                check("head_code", 32'(key_code), 32'(exp_q[0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        clr = 1'b0;
    endtask

    task automatic hold(input logic kr, input logic [3:0] code, input int n);
        for (int i = 0; i < n; i++) begin
            key_read = kr;
            bcd      = kr ? code : 4'($urandom_range(0, 15));
            step();
        end
    endtask

    task automatic press(input logic [3:0] code, input int len, input int rel);
        hold(1'b1, code, len);
        hold(1'b0, 4'h0, rel);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        mon_en = 1;
        step();
        rst_n = 1'b1;

        // Single long press, nothing consumed.
        ready = 1'b0;
        press(4'h7, 10, 6);
        ready = 1'b1; step(); ready = 1'b0;

        // Short glitch, then a code change mid-debounce.
        press(4'h3, 3, 6);
        hold(1'b1, 4'h3, 1); hold(1'b1, 4'h5, 2); hold(1'b0, 4'h0, 6);

        // Release bounce yields one event.
        hold(1'b1, 4'h9, 5);
        hold(1'b0, 4'h0, 2); hold(1'b1, 4'h9, 1); hold(1'b0, 4'h0, 6);
        ready = 1'b1; step(); ready = 1'b0;

        // Overflow, in-order drain, clear.
        for (int c = 1; c <= 5; c++) press(4'(c), 5, 5);
        ready = 1'b1; hold(1'b0, 4'h0, 6); ready = 1'b0;
        clr = 1'b1; step();

        // Push and pop on the same edge while full.
        for (int c = 1; c <= 4; c++) press(4'(c), 5, 5);
        hold(1'b1, 4'hA, 3);
        ready = 1'b1; hold(1'b1, 4'hA, 1); ready = 1'b0;
        hold(1'b1, 4'hA, 2); hold(1'b0, 4'h0, 5);
        ready = 1'b1; hold(1'b0, 4'h0, 6); ready = 1'b0;

        // Reset while debouncing with entries stored (overflow set first).
        for (int c = 11; c <= 15; c++) press(4'(c), 5, 5);
        hold(1'b1, 4'h6, 2);
        rst_n = 1'b0; key_read = 1'b1; step(); rst_n = 1'b1;
        hold(1'b0, 4'h0, 3);

        // Random presses with bounces, random consumer, occasional clear/reset.
        for (int it = 0; it < 300; it++) begin
            logic [3:0] code;
            code  = 4'($urandom_range(0, 15));
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0; step(); rst_n = 1'b1;
            end
            hold(1'b1, code, $urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) hold(1'b1, code ^ 4'h1, 1);
            hold(1'b0, 4'h0, $urandom_range(1, 3));
            if ($urandom_range(0, 2) == 0) hold(1'b1, code, $urandom_range(1, 2));
            hold(1'b0, 4'h0, $urandom_range(1, 8));
        end

        ready = 1'b1;
        hold(1'b0, 4'h0, 2 * DEPTH);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
